// File: rtl/traffic_light_monitor.sv
// Receive-side checker for a three-phase traffic light: decodes phase, times it, flags faults.
// Optional minimum-phase check enabled by defining TRAFFIC_LIGHT_MONITOR_MINLEN_EN.
module traffic_light_monitor #(
  parameter int CNT_W     = 27,
  parameter int MIN_PHASE = 60_000_000,
  parameter int MAX_PHASE = 70_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] phase_len,
  output logic [7:0]       cycle_count,
  output logic             err_seq,
  output logic             err_multi,
  output logic             err_timeout,
  output logic             err_short
);

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_INIT   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PHASE);
`ifdef TRAFFIC_LIGHT_MONITOR_MINLEN_EN
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PHASE);
`endif

  // lamp_q_r bit order: {red, yellow, green}
  logic [2:0]       lamp_q_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  logic             lamp_valid_s;
  logic             lamp_dark_s;
  logic             lamp_multi_s;
  state_t           lamp_state_s;
  logic [CNT_W-1:0] cnt_inc_s;

  function automatic state_t legal_next(input state_t s);
    case (s)
      ST_RED:    legal_next = ST_GREEN;
      ST_GREEN:  legal_next = ST_YELLOW;
      ST_YELLOW: legal_next = ST_RED;
      default:   legal_next = ST_INIT;
    endcase
  endfunction

  assign phase = state_r;

  // Classify the registered lamp code and map a single lit lamp to its phase.
  always_comb begin
    lamp_valid_s = 1'b0;
    lamp_state_s = ST_INIT;
    case (lamp_q_r)
      3'b100: begin lamp_valid_s = 1'b1; lamp_state_s = ST_RED;    end
      3'b001: begin lamp_valid_s = 1'b1; lamp_state_s = ST_GREEN;  end
      3'b010: begin lamp_valid_s = 1'b1; lamp_state_s = ST_YELLOW; end
      default: begin lamp_valid_s = 1'b0; lamp_state_s = ST_INIT; end
    endcase
    lamp_dark_s  = (lamp_q_r == 3'b000);
    lamp_multi_s = !lamp_valid_s && !lamp_dark_s;
    cnt_inc_s    = cnt_r + CNT_ONE;
  end

  // Input register, phase FSM, phase timer, cycle counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_q_r    <= 3'b000;
      state_r     <= ST_INIT;
      cnt_r       <= CNT_ZERO;
      phase_valid <= 1'b0;
      phase_len   <= CNT_ZERO;
      cycle_count <= 8'd0;
      err_seq     <= 1'b0;
      err_multi   <= 1'b0;
      err_timeout <= 1'b0;
`ifdef TRAFFIC_LIGHT_MONITOR_MINLEN_EN
      err_short   <= 1'b0;
`endif
    end else begin
      lamp_q_r    <= {red, yellow, green};
      phase_valid <= 1'b0;
      // Clears come first so any set below in the same cycle wins.
      if (clear_err) begin
        err_seq     <= 1'b0;
        err_multi   <= 1'b0;
        err_timeout <= 1'b0;
`ifdef TRAFFIC_LIGHT_MONITOR_MINLEN_EN
        err_short   <= 1'b0;
`endif
      end
      case (state_r)
        ST_INIT: begin
          if (lamp_valid_s) begin
            state_r <= lamp_state_s;
            cnt_r   <= CNT_ONE;
          end else if (lamp_multi_s) begin
            err_multi <= 1'b1;
          end
        end
        ST_RED, ST_GREEN, ST_YELLOW: begin
          if (lamp_dark_s) begin
            state_r <= ST_INIT;
            cnt_r   <= CNT_ZERO;
          end else if (lamp_multi_s) begin
            err_multi <= 1'b1;
            state_r   <= ST_INIT;
            cnt_r     <= CNT_ZERO;
          end else if (lamp_state_s == state_r) begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == MAX_C) begin
                err_timeout <= 1'b1;
              end
            end
          end else if (lamp_state_s == legal_next(state_r)) begin
            phase_valid <= 1'b1;
            phase_len   <= cnt_r;
            state_r     <= lamp_state_s;
            cnt_r       <= CNT_ONE;
            if (state_r == ST_YELLOW) begin
              cycle_count <= cycle_count + 8'd1;
            end
`ifdef TRAFFIC_LIGHT_MONITOR_MINLEN_EN
            if (cnt_r < MIN_C) begin
              err_short <= 1'b1;
            end
`endif
          end else begin
            err_seq <= 1'b1;
            state_r <= lamp_state_s;
            cnt_r   <= CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

`ifndef TRAFFIC_LIGHT_MONITOR_MINLEN_EN
  assign err_short = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized bench for traffic_light_monitor against a phase/run-length reference model.
module tb_traffic_light_monitor;
  localparam int CNT_W = 8;
  localparam int MIN_P = 4;
  localparam int MAX_P = 10;

  logic clk = 1'b0;
  logic rst_n, red, yellow, green, clear_err;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] phase_len;
  logic [7:0]       cycle_count;
  logic             err_seq, err_multi, err_timeout, err_short;

  traffic_light_monitor #(.CNT_W(CNT_W), .MIN_PHASE(MIN_P), .MAX_PHASE(MAX_P)) dut (
    .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green),
    .clear_err(clear_err), .phase(phase), .phase_valid(phase_valid),
    .phase_len(phase_len), .cycle_count(cycle_count), .err_seq(err_seq),
    .err_multi(err_multi), .err_timeout(err_timeout), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase index 0 red, 1 green, 2 yellow, 3 unknown; run is unbounded.
  logic [2:0] m_lq;
  int m_cur, m_run, m_plen, m_cyc;
  bit m_pv, m_eseq, m_emulti, m_eto, m_eshort;
  int gen_cur;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] lamp_of(input int p);
    case (p)
      0:       return 3'b100;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int idx_of(input logic [2:0] l);
    for (int p = 0; p < 3; p++) if (lamp_of(p) == l) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_lq = 3'b000; m_cur = 3; m_run = 0; m_plen = 0; m_cyc = 0;
    m_pv = 0; m_eseq = 0; m_emulti = 0; m_eto = 0; m_eshort = 0;
  endtask

  task automatic model_step();
    int nv;
    int i;
    if (!rst_n) begin
      model_reset();
    end else begin
      nv = $countones(m_lq);
      i  = idx_of(m_lq);
      m_pv = 0;
      if (clear_err) begin
        m_eseq = 0; m_emulti = 0; m_eto = 0; m_eshort = 0;
      end
      if (m_cur == 3) begin
        if (nv > 1) m_emulti = 1;
        else if (nv == 1) begin m_cur = i; m_run = 1; end
      end else if (nv == 0) begin
        m_cur = 3; m_run = 0;
      end else if (nv > 1) begin
        m_emulti = 1; m_cur = 3; m_run = 0;
      end else if (i == m_cur) begin
        m_run++;
        if (m_run == MAX_P) m_eto = 1;
      end else if (i == (m_cur + 1) % 3) begin
        m_pv = 1;
        m_plen = (m_run > 255) ? 255 : m_run;
        if (m_run < MIN_P) m_eshort = 1;
        if (m_cur == 2) m_cyc = (m_cyc + 1) % 256;
        m_cur = i; m_run = 1;
      end else begin
        m_eseq = 1; m_cur = i; m_run = 1;
      end
      m_lq = {red, yellow, green};
    end
  endtask

  task automatic check_all();
    bit exp_short;
`ifdef TRAFFIC_LIGHT_MONITOR_MINLEN_EN
    exp_short = m_eshort;
`else
    exp_short = 1'b0;
`endif
    check_eq("phase",       32'(phase),       32'(m_cur));
    check_eq("phase_valid", 32'(phase_valid), 32'(m_pv));
    check_eq("phase_len",   32'(phase_len),   32'(m_plen));
    check_eq("cycle_count", 32'(cycle_count), 32'(m_cyc));
    check_eq("err_seq",     32'(err_seq),     32'(m_eseq));
    check_eq("err_multi",   32'(err_multi),   32'(m_emulti));
    check_eq("err_timeout", 32'(err_timeout), 32'(m_eto));
    check_eq("err_short",   32'(err_short),   32'(exp_short));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_seg(input logic [2:0] l, input int len, input int clr_at);
    for (int k = 0; k < len; k++) begin
      {red, yellow, green} = l;
      clear_err = (k == clr_at);
      cycle();
    end
    clear_err = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < n; k++) begin
      {red, yellow, green} = 3'($urandom_range(0, 7));
      clear_err = 1'($urandom_range(0, 1));
      cycle();
    end
    clear_err = 1'b0;
    {red, yellow, green} = 3'b000;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] multi_tab [4];
    logic [2:0] l;
    int r, len, clr_at;
    multi_tab[0] = 3'b011; multi_tab[1] = 3'b101;
    multi_tab[2] = 3'b110; multi_tab[3] = 3'b111;
    rst_n = 1'b0; clear_err = 1'b0; {red, yellow, green} = 3'b000;
    model_reset();
    do_reset(4);

    run_seg(lamp_of(0), 8, -1);
    run_seg(lamp_of(1), 8, -1);
    run_seg(lamp_of(2), 8, -1);
    run_seg(lamp_of(0), 6, -1);
    run_seg(lamp_of(2), 5, 3);
    run_seg(3'b101, 1, -1);
    run_seg(lamp_of(1), 3, -1);
    run_seg(lamp_of(2), 5, -1);
    run_seg(lamp_of(0), 12, 10);
    run_seg(3'b000, 2, 1);
    run_seg(lamp_of(0), 5, -1);
    do_reset(3);
    gen_cur = 0;

    for (int s = 0; s < 1500; s++) begin
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 14);
      clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      if (r < 60) begin
        gen_cur = (gen_cur + 1) % 3; l = lamp_of(gen_cur);
      end else if (r < 72) begin
        gen_cur = $urandom_range(0, 2); l = lamp_of(gen_cur);
      end else if (r < 82) begin
        l = 3'b000; len = $urandom_range(1, 3); clr_at = -1;
      end else if (r < 92) begin
        l = multi_tab[$urandom_range(0, 3)]; len = $urandom_range(1, 2); clr_at = -1;
      end else if (r < 95) begin
        do_reset($urandom_range(1, 3));
        continue;
      end else begin
        gen_cur = (gen_cur + 1) % 3; l = lamp_of(gen_cur);
        len = $urandom_range(255, 262); clr_at = -1;
      end
      run_seg(l, len, clr_at);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the lamp outputs of a three-phase traffic light controller. It samples `red`/`yellow`/`green`, decodes the current phase and enforces the legal sequence RED → GREEN → YELLOW → RED. It measures each phase's length in clock cycles, counts completed light cycles, and raises sticky error flags for illegal transitions, invalid lamp patterns and over-long phases. It sits beside the controller on the same `clk` and provides a board-level self-check and debug taps.

## Interface
- `CNT_W`, 27: width of the phase-length counter and `phase_len`.
- `MIN_PHASE`, 60_000_000: minimum legal phase length in cycles. Used only when the configuration macro is defined.
- `MAX_PHASE`, 70_000_000: phase length, in cycles, at which timeout is flagged. Must be less than 2^CNT_W.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `red`, `yellow`, `green`  in  1 each  lamp lines from the controller, synchronous to `clk`.
- `clear_err`  in  1  synchronous clear of all sticky error flags.
- `phase`  out  2  decoded phase: 00 RED, 01 GREEN, 10 YELLOW, 11 UNKNOWN.
- `phase_valid`  out  1  one-cycle pulse when a phase completes via a legal transition.
- `phase_len`  out  CNT_W  length of the last legally completed phase. Held between pulses.
- `cycle_count`  out  8  count of completed YELLOW → RED transitions. Wraps at 255 → 0.
- `err_seq`, `err_multi`, `err_timeout`, `err_short`  out  1 each  sticky error flags.

## Operation
- Input stage: the three lamp inputs are registered once into `lamp_q`. The FSM acts only on `lamp_q`.
- Code classification:
  - Exactly one lamp lit: valid.
  - All lamps off: dark.
  - Two or more lamps lit: multi.
- FSM states: INIT, RED, GREEN, YELLOW. `phase` = 11 in INIT, otherwise the state encoding. Reset state is INIT.
- INIT:
  - Dark: stay in INIT, no error.
  - Multi: set `err_multi`, stay in INIT.
  - Valid: go to the matching state, counter ← 1, no `phase_valid`.
- RED/GREEN/YELLOW, evaluated on `lamp_q`:
  - Same lamp: counter increments, saturating at 2^CNT_W−1. When the counter reaches MAX_PHASE, set `err_timeout` and stay in the state.
  - Legal next lamp: pulse `phase_valid`, `phase_len` ← counter, counter ← 1, advance state. On YELLOW → RED also increment `cycle_count`.
  - Other valid lamp (illegal jump, e.g. RED → YELLOW): set `err_seq`, resync to the lamp's state, counter ← 1. No `phase_valid`, `phase_len` unchanged.
  - Dark: return to INIT, counter ← 0, no error.
  - Multi: set `err_multi`, return to INIT, counter ← 0.
- Sticky flags: cleared by `clear_err`. If a set condition and `clear_err` occur in the same cycle, set wins.
- Reset mid-phase: all state is discarded. After release, the first valid lamp enters its state with no `phase_valid` and no error.

## Timing
- Latency: a lamp change at `clk` edge k is captured in `lamp_q` at edge k; state, `phase`, `phase_valid` and errors update at edge k+1. Input-to-output latency is 2 edges.
- `phase_len` equals the number of cycles the lamp was sampled lit (counter starts at 1 on entry). It updates in the same cycle as `phase_valid`.
- `phase_valid` is high for exactly one cycle per legal transition. Back-to-back transitions give back-to-back pulses.
- `err_timeout` sets in the cycle the counter equals MAX_PHASE. It does not re-pulse while saturated.
- Reset values: `phase` = 11, `phase_len` = 0, `cycle_count` = 0; `phase_valid`, all error flags, counter and `lamp_q` = 0.

## Configuration
- Macro: `TRAFFIC_LIGHT_MONITOR_MINLEN_EN`.
- Defined: on a legal transition with counter < MIN_PHASE, set `err_short`. The transition, `phase_valid` and `phase_len` behave normally.
- Undefined: `err_short` is tied to 0 and no MIN_PHASE comparator is built.

## Test plan
All scenarios use bench parameters CNT_W=8, MIN_PHASE=4, MAX_PHASE=10.
- Reset with lamps toggling → all outputs at reset values, `phase`=11; after release, red lit → `phase`=00 two edges later, no `phase_valid`.
- Red 8, green 8, yellow 8 cycles, then red → three `phase_valid` pulses with `phase_len`=8 (first ignored entry excluded), `cycle_count`=1, all errors 0.
- Red 6 cycles then yellow → `err_seq`=1, `phase`=10, no `phase_valid`, `phase_len` unchanged. Pulsing `clear_err` → `err_seq`=0.
- Red and green lit together for 1 cycle → `err_multi`=1, `phase`=11. Then green alone → `phase`=01 with no `err_seq`.
- Red held 12 cycles → `err_timeout` rises when the counter reaches 10. `clear_err` asserted in the same cycle as the rise → flag remains 1.
- Green held 3 cycles then yellow → `err_short`=1 and `phase_len`=3 with the macro defined; `err_short`=0 with it undefined.
